logic16_arbiter: RTL and testbench

LOGIC16_ARBITER -- requirements
Module: logic16_arbiter

---
 rtl/logic16_arbiter.sv | 158 +++++++++++++++
 tb/tb_logic16_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic16_arbiter.sv
// logic16_arbiter: one WIDTH-bit bitwise logic unit shared by two requesters.
// A three-state FSM (idle -> exec -> resp) grants one requester at a time with
// round-robin priority. It captures the granted operands, computes the result
// in a single cycle, and then holds the result until the consumer takes it.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   reqN_valid/op/a/b          requester N operation (op: 00 AND, 01 OR, 10 XOR, 11 NOT a)
//   reqN_ready                 requester N accepted this cycle (combinational, idle only)
//   rsp_valid/id/data          registered result, owner index and data
//   rsp_ready                  consumer accepts the result
//   busy                       FSM is not idle
module logic16_arbiter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             rsp_ready,
  output logic             busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic             grant0, grant1;
  logic [WIDTH-1:0] alu_result;

  // Round-robin grant. It is only offered in idle and never while reset is
  // high, so a reset edge can never coincide with an accepted request.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == StIdle && !reset) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Shared bitwise unit, fed only from the captured operands.
  always_comb begin
    unique case (op_q)
      2'b00:   alu_result = a_q & b_q;
      2'b01:   alu_result = a_q | b_q;
      2'b10:   alu_result = a_q ^ b_q;
      default: alu_result = ~a_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;

    unique case (state_q)
      StIdle: begin
        if (grant0) begin
          op_d         = req0_op;
          a_d          = req0_a;
          b_d          = req0_b;
          id_d         = 1'b0;
          last_grant_d = 1'b0;
          state_d      = StExec;
        end else if (grant1) begin
          op_d         = req1_op;
          a_d          = req1_a;
          b_d          = req1_b;
          id_d         = 1'b1;
          last_grant_d = 1'b1;
          state_d      = StExec;
        end
      end
      StExec: begin
        rsp_data_d  = alu_result;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;  // requester 0 wins the first tie
      op_q         <= 2'b00;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_logic16_arbiter.sv
// Self-checking bench for logic16_arbiter. Accepted requests push their
// expected result into a scoreboard; delivered responses pop and compare it.
module tb_logic16_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [1:0]  req0_op, req1_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_id, rsp_ready, busy;
  logic [15:0] rsp_data;

  int unsigned n_tests = 0;
  int unsigned n_failed = 0;
  int          cyc = 0;
  logic        rsp_valid_prev = 1'b0;

  logic [16:0] exp_q[$];     // {id, data}
  int          lat_q[$];     // handshake cycle of each outstanding op
  logic        grant_log[$];

  logic16_arbiter #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0_valid(req0_valid),
    .req0_op   (req0_op),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_op   (req1_op),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_ready(req1_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] model_op(input logic [1:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  // Scoreboard monitor, sampling away from the active edge.
  always @(negedge clk) begin
    logic [16:0] e;
    if (reset) begin
      exp_q.delete();
      lat_q.delete();
      check_eq("ready_in_reset", 32'({req0_ready, req1_ready}), 32'h0);
    end else begin
      if (rsp_valid && !rsp_valid_prev) begin
        if (lat_q.size() > 0) check_eq("latency", 32'(cyc - lat_q.pop_front()), 32'd2);
        else check_eq("spurious_rsp", 32'd1, 32'd0);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("rsp_id", 32'(rsp_id), 32'(e[16]));
          check_eq("rsp_data", 32'(rsp_data), 32'(e[15:0]));
        end else begin
          check_eq("unexpected_rsp", 32'd1, 32'd0);
        end
      end
      if (req0_valid || req1_valid)
        check_eq("ready_onehot", 32'(req0_ready && req1_ready), 32'h0);
      if (req0_valid && req0_ready) begin
        exp_q.push_back({1'b0, model_op(req0_op, req0_a, req0_b)});
        lat_q.push_back(cyc);
        grant_log.push_back(1'b0);
      end
      if (req1_valid && req1_ready) begin
        exp_q.push_back({1'b1, model_op(req1_op, req1_a, req1_b)});
        lat_q.push_back(cyc);
        grant_log.push_back(1'b1);
      end
    end
    rsp_valid_prev = rsp_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic set_req0(input logic v, input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic set_req1(input logic v, input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  // Wait until all accepted work has been delivered and the FSM is idle.
  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check_eq("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_rsp_valid(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check_eq("rsp_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    rsp_ready = 1'b1;
    set_req0(1'b0, 2'b00, 16'h0, 16'h0);
    set_req1(1'b0, 2'b00, 16'h0, 16'h0);
    step();
    step();
    @(negedge clk);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_eq("rst_rsp_id", 32'(rsp_id), 32'h0);
    check_eq("rst_rsp_data", 32'(rsp_data), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    step();
    reset = 1'b0;

    // Single OR from requester 0, latency 2.
    set_req0(1'b1, 2'b01, 16'h00F0, 16'h0F00);
    @(negedge clk);
    check_eq("t1_req0_ready", 32'(req0_ready), 32'h1);
    step();
    set_req0(1'b0, 2'b11, 16'hFFFF, 16'hFFFF);
    @(negedge clk);
    check_eq("t1_exec_busy", 32'(busy), 32'h1);
    check_eq("t1_exec_rsp_valid", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    check_eq("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("t1_rsp_data", 32'(rsp_data), 32'h0FF0);
    check_eq("t1_rsp_id", 32'(rsp_id), 32'h0);
    step();
    drain(20);

    // Simultaneous requests after reset: requester 0 wins first.
    do_reset();
    set_req0(1'b1, 2'b00, 16'hFF00, 16'h0FF0);
    set_req1(1'b1, 2'b10, 16'hFFFF, 16'h1234);
    @(negedge clk);
    check_eq("t2_req0_ready", 32'(req0_ready), 32'h1);
    check_eq("t2_req1_ready", 32'(req1_ready), 32'h0);
    step();
    req0_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!req1_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("t2_req1_granted", 32'(req1_ready), 32'h1);
    step();
    req1_valid = 1'b0;
    drain(20);

    // Back-pressure: result must hold while rsp_ready is low.
    rsp_ready = 1'b0;
    set_req0(1'b1, 2'b10, 16'h5A5A, 16'h0FF0);
    step();
    set_req0(1'b0, 2'b00, 16'h0, 16'h0);
    set_req1(1'b1, 2'b01, 16'h1100, 16'h0011);
    wait_rsp_valid(10);
    for (int i = 0; i < 5; i++) begin
      check_eq("t3_hold_data", 32'(rsp_data), 32'h55AA);
      check_eq("t3_hold_id", 32'(rsp_id), 32'h0);
      check_eq("t3_hold_valid", 32'(rsp_valid), 32'h1);
      check_eq("t3_hold_readys", 32'({req0_ready, req1_ready}), 32'h0);
      check_eq("t3_hold_busy", 32'(busy), 32'h1);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("t3_deliver", 32'(rsp_valid), 32'h1);
    step();
    req1_valid = 1'b0;
    @(negedge clk);
    check_eq("t3_after_valid", 32'(rsp_valid), 32'h0);
    drain(20);

    // Both continuously valid: grants alternate 0,1,0,1.
    do_reset();
    grant_log.delete();
    set_req0(1'b1, 2'b00, 16'hF0F0, 16'h3C3C);
    set_req1(1'b1, 2'b01, 16'h0F00, 16'h00F0);
    n = 0;
    while (grant_log.size() < 4 && n < 40) begin
      step();
      n++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_eq("t4_grant_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < grant_log.size()) check_eq("t4_grant_order", 32'(grant_log[i]), 32'(i % 2));
    end
    drain(20);

    // Reset during exec aborts the operation.
    set_req0(1'b1, 2'b00, 16'hFFFF, 16'h1234);
    @(negedge clk);
    check_eq("t5_req0_ready", 32'(req0_ready), 32'h1);
    step();
    req0_valid = 1'b0;
    reset = 1'b1;
    step();
    req0_valid = 1'b1;
    @(negedge clk);
    check_eq("t5_abort_valid", 32'(rsp_valid), 32'h0);
    check_eq("t5_abort_busy", 32'(busy), 32'h0);
    check_eq("t5_abort_data", 32'(rsp_data), 32'h0);
    check_eq("t5_ready_in_reset", 32'(req0_ready), 32'h0);
    step();
    req0_valid = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check_eq("t5_no_delivery", 32'(rsp_valid), 32'h0);

    // NOT ignores b.
    set_req1(1'b1, 2'b11, 16'h0000, 16'hABCD);
    @(negedge clk);
    check_eq("t6_req1_ready", 32'(req1_ready), 32'h1);
    step();
    req1_valid = 1'b0;
    req1_a = 16'h1234;
    @(negedge clk);
    @(negedge clk);
    check_eq("t6_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("t6_rsp_data", 32'(rsp_data), 32'hFFFF);
    check_eq("t6_rsp_id", 32'(rsp_id), 32'h1);
    step();
    drain(20);
    check_eq("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
